branch_predictor: RTL and testbench

- Parametrised direct-mapped branch history table plus branch target buffer for the 5-stage MIPS pipeline.
- Lookup happens in IF: it gives a predicted next PC so that taken branches and jumps no longer always flush IF/ID.
- Update happens in EX from the resolved outcome. The block flags a mispredict and supplies the corrected PC.
- Keeps its own prediction statistics counters, next to the existing cycle, branch and bubble counters.

---
 rtl/branch_predictor.sv | 139 +++++++++++++
 tb/tb_branch_predictor.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch history table + branch target buffer for the 5-stage MIPS pipeline.
// Lookup is combinational in IF; the resolved outcome from EX trains the table and flags redirects.
module branch_predictor #(
  parameter int ADDR_BITS = 12,
  parameter int IDX_BITS  = 4,
  parameter int CTR_BITS  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_en,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] correct_pc,
  input  logic        stat_clr,
  output logic [31:0] lookup_cnt,
  output logic [31:0] hit_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int TAG_BITS = ADDR_BITS - 2 - IDX_BITS;
  localparam int TGT_BITS = ADDR_BITS - 2;
  localparam int ENTRIES  = 2 ** IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

  if (IDX_BITS < 1 || TAG_BITS < 1) begin : g_bad_params
    $error("branch_predictor: IDX_BITS and TAG_BITS must both be at least 1");
  end

  function automatic logic [CTR_BITS-1:0] ctr_inc(input logic [CTR_BITS-1:0] c);
    return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
  endfunction

  function automatic logic [CTR_BITS-1:0] ctr_dec(input logic [CTR_BITS-1:0] c);
    return (c == '0) ? c : c - CTR_BITS'(1);
  endfunction

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_d [ENTRIES];
  logic [TGT_BITS-1:0] tgt_q [ENTRIES];
  logic [TGT_BITS-1:0] tgt_d [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d [ENTRIES];
  logic [31:0]         lookup_cnt_q, lookup_cnt_d;
  logic [31:0]         hit_cnt_q, hit_cnt_d;
  logic [31:0]         mispred_cnt_q, mispred_cnt_d;

  logic [IDX_BITS-1:0] lk_idx, upd_idx;
  logic [TAG_BITS-1:0] lk_tag, upd_tag;
  logic [TGT_BITS-1:0] upd_tgt;
  logic                lk_hit, upd_hit;
  logic                unused_bits;

  assign lk_idx  = if_pc[IDX_BITS+1:2];
  assign lk_tag  = if_pc[ADDR_BITS-1:IDX_BITS+2];
  assign upd_idx = upd_pc[IDX_BITS+1:2];
  assign upd_tag = upd_pc[ADDR_BITS-1:IDX_BITS+2];
  assign upd_tgt = upd_target[ADDR_BITS-1:2];

  // PC bits outside the tracked address window carry no information for the table
  assign unused_bits = ^{if_pc[31:ADDR_BITS], if_pc[1:0], upd_pc[31:ADDR_BITS], upd_pc[1:0],
                         upd_target[31:ADDR_BITS], upd_target[1:0]};

  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign pred_taken  = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
  assign pred_target = pred_taken ? {{(32-ADDR_BITS){1'b0}}, tgt_q[lk_idx], 2'b00}
                                  : if_pc + 32'd4;

  assign mispredict = rst && upd_valid &&
                      ((upd_pred_taken != upd_taken) ||
                       (upd_taken && (upd_pred_target != upd_target)));
  assign correct_pc = upd_taken ? upd_target : upd_pc + 32'd4;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          ctr_d[upd_idx] = ctr_inc(ctr_q[upd_idx]);
          tgt_d[upd_idx] = upd_tgt;
        end else begin
          ctr_d[upd_idx] = ctr_dec(ctr_q[upd_idx]);
        end
      end else if (upd_taken) begin
        // Allocation evicts whatever aliased entry lived at this index
        valid_d[upd_idx] = 1'b1;
        tag_d[upd_idx]   = upd_tag;
        tgt_d[upd_idx]   = upd_tgt;
        ctr_d[upd_idx]   = CTR_WEAK;
      end
    end
  end

  always_comb begin
    lookup_cnt_d  = stat_clr ? 32'd0 : lookup_cnt_q + 32'(lookup_en);
    hit_cnt_d     = stat_clr ? 32'd0 : hit_cnt_q + 32'(lookup_en & lk_hit);
    mispred_cnt_d = stat_clr ? 32'd0 : mispred_cnt_q + 32'(mispredict);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q       <= '0;
      lookup_cnt_q  <= '0;
      hit_cnt_q     <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= '0;
    end else begin
      valid_q       <= valid_d;
      ctr_q         <= ctr_d;
      lookup_cnt_q  <= lookup_cnt_d;
      hit_cnt_q     <= hit_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Tag and target are qualified by valid, so they need no reset
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

  assign lookup_cnt  = lookup_cnt_q;
  assign hit_cnt     = hit_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: expectations are queued as stimulus is
// driven and popped against the DUT outputs once they are due.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_en;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] correct_pc;
  logic        stat_clr;
  logic [31:0] lookup_cnt;
  logic [31:0] hit_cnt;
  logic [31:0] mispred_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  branch_predictor dut (
    .clk             (clk),
    .rst             (rst),
    .lookup_en       (lookup_en),
    .if_pc           (if_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .correct_pc      (correct_pc),
    .stat_clr        (stat_clr),
    .lookup_cnt      (lookup_cnt),
    .hit_cnt         (hit_cnt),
    .mispred_cnt     (mispred_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] obs(input string tag);
    case (tag)
      "pred_taken":  return {31'b0, pred_taken};
      "pred_target": return pred_target;
      "mispredict":  return {31'b0, mispredict};
      "correct_pc":  return correct_pc;
      "lookup_cnt":  return lookup_cnt;
      "hit_cnt":     return hit_cnt;
      "mispred_cnt": return mispred_cnt;
      default:       return 'x;
    endcase
  endfunction

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (obs(e.tag) === e.exp) else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs(e.tag), e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
  endtask

  initial begin
    rst = 1'b0; lookup_en = 1'b0; if_pc = 32'h10; stat_clr = 1'b0;
    set_upd(32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
    #1;
    // reset values, with a would-be mispredict presented during reset
    expect_val("pred_taken", 32'd0);
    expect_val("pred_target", 32'h14);
    expect_val("mispredict", 32'd0);
    expect_val("lookup_cnt", 32'd0);
    expect_val("hit_cnt", 32'd0);
    expect_val("mispred_cnt", 32'd0);
    drain();
    step(); step();
    upd_valid = 1'b0; rst = 1'b1; lookup_en = 1'b1; if_pc = 32'h10;
    step(); step(); step();
    expect_val("pred_taken", 32'd0);
    expect_val("pred_target", 32'h14);
    expect_val("lookup_cnt", 32'd3);
    expect_val("hit_cnt", 32'd0);
    drain();
    lookup_en = 1'b0;

    // first allocation at 0x10 -> 0x40
    set_upd(32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
    #1;
    expect_val("mispredict", 32'd1);
    expect_val("correct_pc", 32'h40);
    expect_val("pred_taken", 32'd0);
    drain();
    step();
    upd_valid = 1'b0; lookup_en = 1'b1;
    #1;
    expect_val("mispred_cnt", 32'd1);
    expect_val("pred_taken", 32'd1);
    expect_val("pred_target", 32'h40);
    drain();
    step();
    lookup_en = 1'b0;
    expect_val("hit_cnt", 32'd1);
    expect_val("lookup_cnt", 32'd4);
    drain();

    // saturate, then walk back down
    repeat (3) begin
      set_upd(32'h10, 1'b1, 32'h40, 1'b1, 32'h40);
      #1;
      expect_val("mispredict", 32'd0);
      drain();
      step();
    end
    set_upd(32'h10, 1'b0, 32'h40, 1'b1, 32'h40);
    #1;
    expect_val("mispredict", 32'd1);
    expect_val("correct_pc", 32'h14);
    drain();
    step();
    upd_valid = 1'b0;
    #1;
    expect_val("pred_taken", 32'd1);
    expect_val("pred_target", 32'h40);
    drain();
    set_upd(32'h10, 1'b0, 32'h40, 1'b1, 32'h40);
    step();
    upd_valid = 1'b0; lookup_en = 1'b1;
    #1;
    expect_val("pred_taken", 32'd0);
    expect_val("pred_target", 32'h14);
    expect_val("mispred_cnt", 32'd3);
    drain();
    step();
    lookup_en = 1'b0;
    expect_val("hit_cnt", 32'd2);
    expect_val("lookup_cnt", 32'd5);
    drain();

    // aliasing: 0x50 shares index 4 with 0x10 and evicts it
    set_upd(32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
    step();
    set_upd(32'h50, 1'b1, 32'h80, 1'b0, 32'h54);
    step();
    upd_valid = 1'b0; if_pc = 32'h10;
    #1;
    expect_val("pred_taken", 32'd0);
    expect_val("pred_target", 32'h14);
    expect_val("mispred_cnt", 32'd5);
    drain();
    if_pc = 32'h50;
    #1;
    expect_val("pred_taken", 32'd1);
    expect_val("pred_target", 32'h80);
    drain();

    // not-taken miss must not allocate
    set_upd(32'h60, 1'b0, 32'hA0, 1'b0, 32'h64);
    lookup_en = 1'b1; if_pc = 32'h60;
    #1;
    expect_val("mispredict", 32'd0);
    expect_val("correct_pc", 32'h64);
    drain();
    step();
    upd_valid = 1'b0; lookup_en = 1'b0;
    expect_val("pred_taken", 32'd0);
    expect_val("hit_cnt", 32'd2);
    expect_val("lookup_cnt", 32'd6);
    expect_val("mispred_cnt", 32'd5);
    drain();

    // same-cycle lookup and allocation at 0x20, with a target mismatch
    set_upd(32'h20, 1'b1, 32'h48, 1'b1, 32'h44);
    lookup_en = 1'b1; if_pc = 32'h20;
    #1;
    expect_val("mispredict", 32'd1);
    expect_val("correct_pc", 32'h48);
    expect_val("pred_taken", 32'd0);
    expect_val("pred_target", 32'h24);
    drain();
    step();
    upd_valid = 1'b0;
    expect_val("pred_taken", 32'd1);
    expect_val("pred_target", 32'h48);
    expect_val("hit_cnt", 32'd2);
    expect_val("mispred_cnt", 32'd6);
    expect_val("lookup_cnt", 32'd7);
    drain();
    step();
    lookup_en = 1'b0;
    expect_val("hit_cnt", 32'd3);
    expect_val("lookup_cnt", 32'd8);
    drain();

    // target is irrelevant when both predicted and actual are not-taken
    set_upd(32'h70, 1'b0, 32'h48, 1'b0, 32'h44);
    #1;
    expect_val("mispredict", 32'd0);
    expect_val("correct_pc", 32'h74);
    drain();
    upd_valid = 1'b0;

    // mispredict counter wrap
    @(negedge clk);
    force dut.mispred_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.mispred_cnt_q;
    expect_val("mispred_cnt", 32'hFFFF_FFFF);
    drain();
    set_upd(32'h30, 1'b1, 32'h90, 1'b0, 32'h34);
    step();
    upd_valid = 1'b0;
    expect_val("mispred_cnt", 32'd0);
    drain();

    // stat_clr wins over increments and leaves the table alone
    set_upd(32'h30, 1'b1, 32'h90, 1'b0, 32'h34);
    stat_clr = 1'b1; lookup_en = 1'b1; if_pc = 32'h50;
    #1;
    expect_val("mispredict", 32'd1);
    drain();
    step();
    stat_clr = 1'b0; upd_valid = 1'b0;
    expect_val("mispred_cnt", 32'd0);
    expect_val("lookup_cnt", 32'd0);
    expect_val("hit_cnt", 32'd0);
    expect_val("pred_taken", 32'd1);
    expect_val("pred_target", 32'h80);
    drain();
    step();
    expect_val("lookup_cnt", 32'd1);
    expect_val("hit_cnt", 32'd1);
    drain();

    // asynchronous reset in the middle of an update
    set_upd(32'h34, 1'b1, 32'hC0, 1'b0, 32'h38);
    #1;
    expect_val("mispredict", 32'd1);
    drain();
    rst = 1'b0;
    #1;
    expect_val("pred_taken", 32'd0);
    expect_val("pred_target", 32'h54);
    expect_val("mispredict", 32'd0);
    expect_val("lookup_cnt", 32'd0);
    expect_val("hit_cnt", 32'd0);
    expect_val("mispred_cnt", 32'd0);
    drain();
    step();
    rst = 1'b1; upd_valid = 1'b0; lookup_en = 1'b0; if_pc = 32'h34;
    #1;
    expect_val("pred_taken", 32'd0);
    expect_val("pred_target", 32'h38);
    drain();
    if_pc = 32'h50;
    #1;
    expect_val("pred_taken", 32'd0);
    expect_val("pred_target", 32'h54);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
